branch_flag_unit: RTL and testbench
===================================

Name: branch_flag_unit

Overview:
Parametrised successor to the single-flag branch comparator. On a CMP instruction it latches a full flag set (equal, signed less-than, unsigned less-than) into a flag register. It then resolves conditional branches against those flags through a one-stage registered resolve port with optional same-cycle flag bypass. It sits between the register-file read stage and the PC-select logic.

Parameters:
WIDTH, 16, operand width in bits (>=2)
BYPASS, 1, 1 = a branch issued in the same cycle as a CMP uses the new flags; 0 = it uses the previously latched flags
COND_W, 3, width of the branch condition code

Ports:
clk  input  1  system clock
reset  input  1  active-high asynchronous reset
data1  input  WIDTH  compare operand A
data2  input  WIDTH  compare operand B
opcode  input  OPCODE_W (shared defines)  current instruction opcode
op_valid  input  1  opcode/operands valid this cycle
stall  input  1  freeze all registers, outputs held
br_req  input  1  branch resolve request
br_cond  input  COND_W  condition code
flag_eq  output  1  latched data1==data2
flag_lt  output  1  latched signed data1<data2
flag_ltu  output  1  latched unsigned data1<data2
flags_valid  output  1  a CMP has completed since reset
br_valid  output  1  resolve result valid (1-cycle pulse)
br_taken  output  1  branch taken, qualified by br_valid
br_err  output  1  pulse: branch resolved with no valid flags

Behaviour:
- Interface: one clock; reset is asynchronous and active-high. Clock port clk, reset port reset.
- Reset: all outputs and internal registers go to 0 immediately on reset assertion, independent of clk. Registers release on the first clk edge after deassertion.
- Compare: cmp_fire = op_valid & (opcode==CMP) & ~stall.
  - eq = (data1==data2).
  - ltu = unsigned compare.
  - lt = signed two's-complement compare, i.e. an MSB-differ case resolved by data1[MSB].
- On cmp_fire the flags latch at the next edge and flags_valid sets to 1. It stays 1 until reset.
- Flags are sticky: they change only on cmp_fire. Non-CMP opcodes and op_valid=0 leave them unchanged.
- Condition codes (shared constants):
  - 0 BEQ: eq
  - 1 BNE: ~eq
  - 2 BLT: lt
  - 3 BGE: ~lt
  - 4 BLTU: ltu
  - 5 BGEU: ~ltu
  - 6 ALWAYS: 1
  - 7 NEVER: 0
- Resolve: br_fire = br_req & ~stall. br_valid is registered and pulses for 1 cycle, 1 cycle after br_fire (latency 1). br_taken is registered with it.
- Flag source for resolve:
  - If cmp_fire and br_fire coincide and BYPASS=1: use the freshly computed flags and treat the flags as valid.
  - Otherwise: use the latched flags.
- No valid flags (flags_valid=0 and no bypass):
  - ALWAYS: br_taken=1, br_err=0.
  - NEVER: br_taken=0, br_err=0.
  - All other codes: br_taken=0 and br_err pulses with br_valid.
- Outside a br_valid cycle, br_taken and br_err are 0.
- Stall: all registers hold, including br_valid. A pending br_valid pulse is held high for the whole stall and clears on the first non-stall edge.
- Reset mid-operation: a pending br_valid is dropped; no pulse after reset.
- Back-to-back br_fire on consecutive cycles gives consecutive br_valid pulses, each using the flags in effect at its own issue cycle.

Decomposition:
- Shared defines package:
  - WORD/OPCODE widths
  - CMP opcode
  - condition-code constants BEQ..NEVER
  - COND_W
- One natural sub-module: flag_compute. It is combinational, parametrised by WIDTH, and produces eq/lt/ltu from data1/data2. It is reused for the bypass path and the latch path.
- The top holds the flag register, the resolve pipeline register and the condition mux.

Test Plan:
- Reset then br_req BEQ with no CMP -> br_valid=1, br_taken=0, br_err=1 next cycle. Repeat with ALWAYS -> br_taken=1, br_err=0.
- WIDTH=16, CMP data1=0xFFFF, data2=0x0001 -> flag_eq=0, flag_lt=1 (signed -1<1), flag_ltu=0. BLT taken, BLTU not taken, BGEU taken.
- CMP 0x1234 vs 0x1234, then 3 non-CMP cycles, then BEQ -> flags unchanged, flag_eq=1, br_taken=1. Then CMP 5 vs 7 with op_valid=0 -> flags unchanged.
- Same-cycle CMP 3 vs 3 + BEQ, with prior flags eq=0 -> BYPASS=1: br_taken=1. BYPASS=0: br_taken=0.
- br_req BNE with stall asserted for 2 cycles on the request cycle -> no br_valid until stall drops. Then one pulse, exactly 1 cycle after the unstalled request.
- Assert reset asynchronously, mid-cycle, while br_valid is pending -> all outputs 0 before the next edge. flags_valid=0 and no br_valid after release.

Source files
------------

// File: rtl/branch_flag_unit_pkg.sv
// Shared defines for the branch flag unit: widths, the CMP opcode and branch condition codes.
package branch_flag_unit_pkg;

    localparam int unsigned WORD_W   = 16;
    localparam int unsigned OPCODE_W = 4;
    localparam int unsigned COND_W   = 3;

    localparam logic [OPCODE_W-1:0] OP_CMP = 4'h5;

    localparam logic [COND_W-1:0] COND_BEQ    = 3'd0;
    localparam logic [COND_W-1:0] COND_BNE    = 3'd1;
    localparam logic [COND_W-1:0] COND_BLT    = 3'd2;
    localparam logic [COND_W-1:0] COND_BGE    = 3'd3;
    localparam logic [COND_W-1:0] COND_BLTU   = 3'd4;
    localparam logic [COND_W-1:0] COND_BGEU   = 3'd5;
    localparam logic [COND_W-1:0] COND_ALWAYS = 3'd6;
    localparam logic [COND_W-1:0] COND_NEVER  = 3'd7;

endpackage

// File: rtl/branch_flag_unit_if.sv
// Operand, compare and branch-resolve signals between the pipeline and the branch flag unit.
interface branch_flag_unit_if #(
    parameter int unsigned WIDTH  = branch_flag_unit_pkg::WORD_W,
    parameter int unsigned COND_W = branch_flag_unit_pkg::COND_W
);
    import branch_flag_unit_pkg::*;

    logic [WIDTH-1:0]    data1;
    logic [WIDTH-1:0]    data2;
    logic [OPCODE_W-1:0] opcode;
    logic                op_valid;
    logic                stall;
    logic                br_req;
    logic [COND_W-1:0]   br_cond;
    logic                flag_eq;
    logic                flag_lt;
    logic                flag_ltu;
    logic                flags_valid;
    logic                br_valid;
    logic                br_taken;
    logic                br_err;

    modport master (
        output data1, data2, opcode, op_valid, stall, br_req, br_cond,
        input  flag_eq, flag_lt, flag_ltu, flags_valid, br_valid, br_taken, br_err
    );

    modport slave (
        input  data1, data2, opcode, op_valid, stall, br_req, br_cond,
        output flag_eq, flag_lt, flag_ltu, flags_valid, br_valid, br_taken, br_err
    );

endinterface

// File: rtl/branch_flag_unit_flag_compute.sv
// Combinational equal / signed-less-than / unsigned-less-than compare of two operands.
module branch_flag_unit_flag_compute #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    output logic             eq,
    output logic             lt,
    output logic             ltu
);

    always_comb begin
        eq  = (data1 == data2);
        ltu = (data1 < data2);
        // Differing sign bits: the negative operand is the smaller one.
        lt  = (data1[WIDTH-1] != data2[WIDTH-1]) ? data1[WIDTH-1] : ltu;
    end

endmodule

// File: rtl/branch_flag_unit.sv
// Latches CMP flags and resolves conditional branches against them with a one-cycle result.
module branch_flag_unit #(
    parameter int unsigned WIDTH  = branch_flag_unit_pkg::WORD_W,
    parameter bit          BYPASS = 1'b1,
    parameter int unsigned COND_W = branch_flag_unit_pkg::COND_W
) (
    input logic                clk,
    input logic                reset,
    branch_flag_unit_if.slave  bus
);
    import branch_flag_unit_pkg::*;

    logic new_eq, new_lt, new_ltu;
    logic cmp_fire, br_fire, use_bypass;
    logic src_valid, src_eq, src_lt, src_ltu;
    logic cond_hit, taken_d, err_d;

    logic flag_eq_q, flag_lt_q, flag_ltu_q, flags_valid_q;
    logic br_valid_q, br_taken_q, br_err_q;

    // Single compare instance feeds both the flag register and the bypass path.
    branch_flag_unit_flag_compute #(
        .WIDTH (WIDTH)
    ) u_flag_compute (
        .data1 (bus.data1),
        .data2 (bus.data2),
        .eq    (new_eq),
        .lt    (new_lt),
        .ltu   (new_ltu)
    );

    always_comb begin
        cmp_fire   = bus.op_valid && (bus.opcode == OP_CMP) && !bus.stall;
        br_fire    = bus.br_req && !bus.stall;
        use_bypass = BYPASS && cmp_fire && br_fire;

        src_valid = use_bypass || flags_valid_q;
        src_eq    = use_bypass ? new_eq  : flag_eq_q;
        src_lt    = use_bypass ? new_lt  : flag_lt_q;
        src_ltu   = use_bypass ? new_ltu : flag_ltu_q;

        cond_hit = 1'b0;
        case (bus.br_cond)
            COND_W'(COND_BEQ):    cond_hit = src_eq;
            COND_W'(COND_BNE):    cond_hit = !src_eq;
            COND_W'(COND_BLT):    cond_hit = src_lt;
            COND_W'(COND_BGE):    cond_hit = !src_lt;
            COND_W'(COND_BLTU):   cond_hit = src_ltu;
            COND_W'(COND_BGEU):   cond_hit = !src_ltu;
            COND_W'(COND_ALWAYS): cond_hit = 1'b1;
            default:              cond_hit = 1'b0;
        endcase

        // Without flags only the unconditional codes resolve cleanly; the rest flag an error.
        if (src_valid) begin
            taken_d = cond_hit;
            err_d   = 1'b0;
        end else begin
            taken_d = (bus.br_cond == COND_W'(COND_ALWAYS));
            err_d   = (bus.br_cond != COND_W'(COND_ALWAYS)) &&
                      (bus.br_cond != COND_W'(COND_NEVER));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flag_eq_q     <= 1'b0;
            flag_lt_q     <= 1'b0;
            flag_ltu_q    <= 1'b0;
            flags_valid_q <= 1'b0;
            br_valid_q    <= 1'b0;
            br_taken_q    <= 1'b0;
            br_err_q      <= 1'b0;
        end else if (!bus.stall) begin
            if (cmp_fire) begin
                flag_eq_q     <= new_eq;
                flag_lt_q     <= new_lt;
                flag_ltu_q    <= new_ltu;
                flags_valid_q <= 1'b1;
            end
            br_valid_q <= br_fire;
            br_taken_q <= br_fire && taken_d;
            br_err_q   <= br_fire && err_d;
        end
    end

    assign bus.flag_eq     = flag_eq_q;
    assign bus.flag_lt     = flag_lt_q;
    assign bus.flag_ltu    = flag_ltu_q;
    assign bus.flags_valid = flags_valid_q;
    assign bus.br_valid    = br_valid_q;
    assign bus.br_taken    = br_taken_q;
    assign bus.br_err      = br_err_q;

endmodule

// File: tb/tb_branch_flag_unit.sv
// Directed bench: one unit with flag bypass and one without, driven with identical stimulus.
module tb_branch_flag_unit;
    import branch_flag_unit_pkg::*;

    localparam int unsigned W = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [W-1:0]        data1, data2;
    logic [OPCODE_W-1:0] opcode;
    logic                op_valid, stall, br_req;
    logic [COND_W-1:0]   br_cond;

    branch_flag_unit_if #(.WIDTH(W), .COND_W(COND_W)) bus_byp ();
    branch_flag_unit_if #(.WIDTH(W), .COND_W(COND_W)) bus_nob ();

    assign bus_byp.data1 = data1;    assign bus_nob.data1 = data1;
    assign bus_byp.data2 = data2;    assign bus_nob.data2 = data2;
    assign bus_byp.opcode = opcode;  assign bus_nob.opcode = opcode;
    assign bus_byp.op_valid = op_valid;  assign bus_nob.op_valid = op_valid;
    assign bus_byp.stall = stall;    assign bus_nob.stall = stall;
    assign bus_byp.br_req = br_req;  assign bus_nob.br_req = br_req;
    assign bus_byp.br_cond = br_cond;  assign bus_nob.br_cond = br_cond;

    branch_flag_unit #(.WIDTH(W), .BYPASS(1'b1), .COND_W(COND_W)) dut_byp (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_byp)
    );

    branch_flag_unit #(.WIDTH(W), .BYPASS(1'b0), .COND_W(COND_W)) dut_nob (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_nob)
    );

    // {valid, taken, err} and {eq, lt, ltu, flags_valid}
    wire [2:0] br_b = {bus_byp.br_valid, bus_byp.br_taken, bus_byp.br_err};
    wire [2:0] br_n = {bus_nob.br_valid, bus_nob.br_taken, bus_nob.br_err};
    wire [3:0] fl_b = {bus_byp.flag_eq, bus_byp.flag_lt, bus_byp.flag_ltu, bus_byp.flags_valid};
    wire [3:0] fl_n = {bus_nob.flag_eq, bus_nob.flag_lt, bus_nob.flag_ltu, bus_nob.flags_valid};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; data1 = '0; data2 = '0; opcode = '0;
        op_valid = 1'b0; stall = 1'b0; br_req = 1'b0; br_cond = '0;
        #2;
        checks++;
        if ({fl_b, br_b} !== 7'b0) begin
            errors++; $display("FAIL reset_async_byp got %b exp %b", {fl_b, br_b}, 7'b0);
        end
        tick(); tick();
        reset = 1'b0;
        tick();
        checks++;
        if ({fl_n, br_n} !== 7'b0) begin
            errors++; $display("FAIL reset_release_nob got %b exp %b", {fl_n, br_n}, 7'b0);
        end
    endtask

    task automatic test_no_flags();
        br_req = 1'b1; br_cond = COND_BEQ;
        tick();
        br_req = 1'b0;
        checks++;
        if (br_b !== 3'b101) begin
            errors++; $display("FAIL noflag_beq_byp got %b exp %b", br_b, 3'b101);
        end
        checks++;
        if (br_n !== 3'b101) begin
            errors++; $display("FAIL noflag_beq_nob got %b exp %b", br_n, 3'b101);
        end
        tick();
        checks++;
        if (br_b !== 3'b000) begin
            errors++; $display("FAIL noflag_pulse_end got %b exp %b", br_b, 3'b000);
        end
        br_req = 1'b1; br_cond = COND_ALWAYS;
        tick();
        checks++;
        if (br_b !== 3'b110) begin
            errors++; $display("FAIL noflag_always got %b exp %b", br_b, 3'b110);
        end
        br_cond = COND_NEVER;
        tick();
        br_req = 1'b0;
        checks++;
        if (br_n !== 3'b100) begin
            errors++; $display("FAIL noflag_never got %b exp %b", br_n, 3'b100);
        end
        tick();
        checks++;
        if (br_b !== 3'b000) begin
            errors++; $display("FAIL noflag_idle got %b exp %b", br_b, 3'b000);
        end
    endtask

    task automatic test_signed();
        op_valid = 1'b1; opcode = OP_CMP; data1 = 16'hFFFF; data2 = 16'h0001;
        tick();
        op_valid = 1'b0;
        checks++;
        if (fl_b !== 4'b0101) begin
            errors++; $display("FAIL signed_flags_byp got %b exp %b", fl_b, 4'b0101);
        end
        checks++;
        if (fl_n !== 4'b0101) begin
            errors++; $display("FAIL signed_flags_nob got %b exp %b", fl_n, 4'b0101);
        end
        // Back-to-back resolves on consecutive cycles.
        br_req = 1'b1; br_cond = COND_BLT;
        tick();
        checks++;
        if (br_b !== 3'b110) begin
            errors++; $display("FAIL b2b_blt got %b exp %b", br_b, 3'b110);
        end
        br_cond = COND_BLTU;
        tick();
        checks++;
        if (br_b !== 3'b100) begin
            errors++; $display("FAIL b2b_bltu got %b exp %b", br_b, 3'b100);
        end
        br_cond = COND_BGEU;
        tick();
        br_req = 1'b0;
        checks++;
        if (br_b !== 3'b110) begin
            errors++; $display("FAIL b2b_bgeu got %b exp %b", br_b, 3'b110);
        end
        br_cond = COND_BGE;
        tick();
        checks++;
        if (br_b !== 3'b000) begin
            errors++; $display("FAIL b2b_end got %b exp %b", br_b, 3'b000);
        end
    endtask

    task automatic test_sticky();
        op_valid = 1'b1; opcode = OP_CMP; data1 = 16'h1234; data2 = 16'h1234;
        tick();
        opcode = 4'h1; data1 = 16'd5; data2 = 16'd7;
        repeat (3) tick();
        op_valid = 1'b0;
        checks++;
        if (fl_b !== 4'b1001) begin
            errors++; $display("FAIL sticky_nonCmp got %b exp %b", fl_b, 4'b1001);
        end
        br_req = 1'b1; br_cond = COND_BEQ;
        tick();
        br_req = 1'b0;
        checks++;
        if (br_n !== 3'b110) begin
            errors++; $display("FAIL sticky_beq got %b exp %b", br_n, 3'b110);
        end
        opcode = OP_CMP; op_valid = 1'b0;
        tick();
        checks++;
        if (fl_b !== 4'b1001) begin
            errors++; $display("FAIL sticky_opinvalid got %b exp %b", fl_b, 4'b1001);
        end
    endtask

    task automatic test_bypass();
        op_valid = 1'b1; opcode = OP_CMP; data1 = 16'd5; data2 = 16'd7;
        tick();
        checks++;
        if (fl_b !== 4'b0111) begin
            errors++; $display("FAIL bypass_prior got %b exp %b", fl_b, 4'b0111);
        end
        data1 = 16'd3; data2 = 16'd3; br_req = 1'b1; br_cond = COND_BEQ;
        tick();
        op_valid = 1'b0; br_req = 1'b0;
        checks++;
        if (br_b !== 3'b110) begin
            errors++; $display("FAIL bypass_on got %b exp %b", br_b, 3'b110);
        end
        checks++;
        if (br_n !== 3'b100) begin
            errors++; $display("FAIL bypass_off got %b exp %b", br_n, 3'b100);
        end
        checks++;
        if (fl_n !== 4'b1001) begin
            errors++; $display("FAIL bypass_latched got %b exp %b", fl_n, 4'b1001);
        end
        tick();
    endtask

    task automatic test_stall();
        br_req = 1'b1; br_cond = COND_BNE; stall = 1'b1;
        op_valid = 1'b1; opcode = OP_CMP; data1 = 16'd1; data2 = 16'd2;
        tick();
        checks++;
        if (br_b !== 3'b000) begin
            errors++; $display("FAIL stall_req_c1 got %b exp %b", br_b, 3'b000);
        end
        tick();
        checks++;
        if (br_b !== 3'b000) begin
            errors++; $display("FAIL stall_req_c2 got %b exp %b", br_b, 3'b000);
        end
        stall = 1'b0; op_valid = 1'b0;
        tick();
        br_req = 1'b0;
        checks++;
        if (br_b !== 3'b100) begin
            errors++; $display("FAIL stall_release got %b exp %b", br_b, 3'b100);
        end
        checks++;
        if (fl_b !== 4'b1001) begin
            errors++; $display("FAIL stall_cmp_ignored got %b exp %b", fl_b, 4'b1001);
        end
        tick();
        checks++;
        if (br_b !== 3'b000) begin
            errors++; $display("FAIL stall_single_pulse got %b exp %b", br_b, 3'b000);
        end
        // A visible pulse is held for the whole stall.
        br_req = 1'b1; br_cond = COND_ALWAYS;
        tick();
        br_req = 1'b0; stall = 1'b1;
        tick();
        checks++;
        if (br_b !== 3'b110) begin
            errors++; $display("FAIL stall_hold_c1 got %b exp %b", br_b, 3'b110);
        end
        tick();
        checks++;
        if (br_n !== 3'b110) begin
            errors++; $display("FAIL stall_hold_c2 got %b exp %b", br_n, 3'b110);
        end
        stall = 1'b0;
        tick();
        checks++;
        if (br_b !== 3'b000) begin
            errors++; $display("FAIL stall_hold_clear got %b exp %b", br_b, 3'b000);
        end
    endtask

    task automatic test_async_reset();
        br_req = 1'b1; br_cond = COND_BEQ;
        tick();
        checks++;
        if (br_b !== 3'b110) begin
            errors++; $display("FAIL arst_pending got %b exp %b", br_b, 3'b110);
        end
        #3 reset = 1'b1;
        #1;
        checks++;
        if ({fl_b, br_b} !== 7'b0) begin
            errors++; $display("FAIL arst_midcycle_byp got %b exp %b", {fl_b, br_b}, 7'b0);
        end
        checks++;
        if ({fl_n, br_n} !== 7'b0) begin
            errors++; $display("FAIL arst_midcycle_nob got %b exp %b", {fl_n, br_n}, 7'b0);
        end
        br_req = 1'b0;
        tick();
        #2 reset = 1'b0;
        tick();
        checks++;
        if ({fl_b[0], br_b} !== 4'b0) begin
            errors++; $display("FAIL arst_after got %b exp %b", {fl_b[0], br_b}, 4'b0);
        end
        tick();
        checks++;
        if ({fl_n[0], br_n} !== 4'b0) begin
            errors++; $display("FAIL arst_no_pulse got %b exp %b", {fl_n[0], br_n}, 4'b0);
        end
    endtask

    task automatic test_bypass_no_flags();
        op_valid = 1'b1; opcode = OP_CMP; data1 = 16'h8000; data2 = 16'h8000;
        br_req = 1'b1; br_cond = COND_BEQ;
        tick();
        op_valid = 1'b0; br_req = 1'b0;
        checks++;
        if (br_b !== 3'b110) begin
            errors++; $display("FAIL first_cmp_bypass got %b exp %b", br_b, 3'b110);
        end
        checks++;
        if (br_n !== 3'b101) begin
            errors++; $display("FAIL first_cmp_nobypass got %b exp %b", br_n, 3'b101);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_no_flags();
        test_signed();
        test_sticky();
        test_bypass();
        test_stall();
        test_async_reset();
        test_bypass_no_flags();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
